// File: rtl/rast_hit_collect_if.sv
// Handshake/bus bundle between rast sample lanes, the hit collector and the downstream consumer.
// master = rast/consumer side, slave = collector side.
interface rast_hit_collect_if #(
   parameter int SIGFIG = 24,
   parameter int AXIS   = 3,
   parameter int COLORS = 3,
   parameter int LANES  = 2,
   parameter int DEPTH  = 16
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [LANES-1:0][AXIS-1:0][SIGFIG-1:0]   hit_R18S;
   logic [LANES-1:0][COLORS-1:0][SIGFIG-1:0] color_R18U;
   logic [LANES-1:0]                         hit_valid_R18H;
   logic                                     halt_RnnnnL;
   logic [AXIS-1:0][SIGFIG-1:0]              out_hit_S;
   logic [COLORS-1:0][SIGFIG-1:0]            out_color_U;
   logic                                     out_valid_H;
   logic                                     out_ready_H;
   logic [CW-1:0]                            count_U;
   logic                                     overflow_H;
   logic [31:0]                              stat_acc_U;
   logic [31:0]                              stat_drop_U;

   modport master (
      output hit_R18S, color_R18U, hit_valid_R18H, out_ready_H,
      input  halt_RnnnnL, out_hit_S, out_color_U, out_valid_H, count_U, overflow_H,
             stat_acc_U, stat_drop_U
   );

   modport slave (
      input  hit_R18S, color_R18U, hit_valid_R18H, out_ready_H,
      output halt_RnnnnL, out_hit_S, out_color_U, out_valid_H, count_U, overflow_H,
             stat_acc_U, stat_drop_U
   );
endinterface

// File: rtl/rast_hit_collect.sv
// Multi-lane hit collector: compacts up to LANES hits per cycle into a fall-through FIFO and drains one per cycle.
// Optional RAST_HIT_STATS_EN builds saturating accepted/dropped hit counters.
module rast_hit_collect #(
   parameter int SIGFIG      = 24,
   parameter int AXIS        = 3,
   parameter int COLORS      = 3,
   parameter int LANES       = 2,
   parameter int DEPTH       = 16,
   parameter int HALT_THRESH = 6
) (
   input  logic              clk,
   input  logic              rst,
   rast_hit_collect_if.slave io_bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] THRESH_C = CW'(HALT_THRESH);

   logic [AXIS-1:0][SIGFIG-1:0]   r_mem_hit   [DEPTH];
   logic [COLORS-1:0][SIGFIG-1:0] r_mem_color [DEPTH];

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_halt;
   logic          r_overflow;

   logic [CW-1:0] w_free;
   logic [CW-1:0] w_nwr;
   logic [CW-1:0] w_drop;
   logic [CW-1:0] w_count_next;
   logic          w_not_empty;
   logic          w_pop;
   logic          w_lane_we   [LANES];
   logic [PW-1:0] w_lane_addr [LANES];

   assign w_not_empty = (r_count != '0);
   assign w_pop       = w_not_empty && io_bus.out_ready_H;

   // Free space comes from the registered count, so a same-cycle pop never makes room for a write.
   always_comb begin
      logic [CW-1:0] v_slot;
      logic [CW-1:0] v_drop;
      w_free = DEPTH_C - r_count;
      v_slot = '0;
      v_drop = '0;
      for (int i = 0; i < LANES; i++) begin
         w_lane_we[i]   = 1'b0;
         w_lane_addr[i] = '0;
         if (io_bus.hit_valid_R18H[i]) begin
            if (v_slot < w_free) begin
               w_lane_we[i]   = 1'b1;
               w_lane_addr[i] = r_wr_ptr + v_slot[PW-1:0];
               v_slot         = v_slot + CW'(1);
            end else begin
               v_drop = v_drop + CW'(1);
            end
         end
      end
      w_nwr  = v_slot;
      w_drop = v_drop;
   end

   assign w_count_next = r_count + w_nwr - CW'(w_pop);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_halt     <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         r_wr_ptr   <= r_wr_ptr + w_nwr[PW-1:0];
         r_rd_ptr   <= r_rd_ptr + PW'(w_pop);
         r_count    <= w_count_next;
         r_halt     <= ((DEPTH_C - w_count_next) >= THRESH_C);
         r_overflow <= r_overflow | (w_drop != '0);
      end
   end

   // NOTE: storage is not reset; the pointers and count define which entries are meaningful.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (w_lane_we[i]) begin
            r_mem_hit[w_lane_addr[i]]   <= io_bus.hit_R18S[i];
            r_mem_color[w_lane_addr[i]] <= io_bus.color_R18U[i];
         end
      end
   end

   assign io_bus.out_valid_H = w_not_empty;
   assign io_bus.out_hit_S   = w_not_empty ? r_mem_hit[r_rd_ptr]   : '0;
   assign io_bus.out_color_U = w_not_empty ? r_mem_color[r_rd_ptr] : '0;
   assign io_bus.count_U     = r_count;
   assign io_bus.halt_RnnnnL = r_halt;
   assign io_bus.overflow_H  = r_overflow;

`ifdef RAST_HIT_STATS_EN
   logic [31:0] r_stat_acc;
   logic [31:0] r_stat_drop;
   logic [32:0] w_acc_sum;
   logic [32:0] w_drop_sum;

   assign w_acc_sum  = {1'b0, r_stat_acc}  + 33'(w_nwr);
   assign w_drop_sum = {1'b0, r_stat_drop} + 33'(w_drop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat_acc  <= '0;
         r_stat_drop <= '0;
      end else begin
         r_stat_acc  <= w_acc_sum[32]  ? '1 : w_acc_sum[31:0];
         r_stat_drop <= w_drop_sum[32] ? '1 : w_drop_sum[31:0];
      end
   end

   assign io_bus.stat_acc_U  = r_stat_acc;
   assign io_bus.stat_drop_U = r_stat_drop;
`else
   assign io_bus.stat_acc_U  = '0;
   assign io_bus.stat_drop_U = '0;
`endif
endmodule
